// File: rtl/char_osd_pkg.sv
// Shared constants and state encoding for the multi-region char buffer writer.
package char_osd_pkg;

  // Writer FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_DATA   = 3'd2,
    ST_LEN_HI = 3'd3,
    ST_LEN_LO = 3'd4,
    ST_DRAIN  = 3'd5
  } state_t;

  // Header: region id, offset MSB, offset LSB
  localparam int unsigned HDR_BYTES = 3;
  // The length word occupies the last LEN_OFS bytes of each region
  localparam int unsigned LEN_OFS   = 2;

endpackage

// File: rtl/char_region_addr_gen.sv
// Region address generator: turns (region id, offset) into the first write
// address, the exclusive write limit and the two length-word addresses.
// Loaded while the last header byte is accepted; outputs valid one cycle later.
module char_region_addr_gen
  import char_osd_pkg::*;
#(
  parameter int unsigned REGION_SIZE = 256,
  parameter int unsigned AW          = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic [7:0]    region_id,
  input  logic [15:0]   offset,
  output logic [AW-1:0] ptr_start,
  output logic [AW-1:0] ptr_limit,
  output logic [AW-1:0] len_hi_addr,
  output logic [AW-1:0] len_lo_addr
);

  localparam int unsigned RS_LOG2 = $clog2(REGION_SIZE);

  logic [AW-1:0] base_s;
  logic [AW-1:0] start_d, start_q;
  logic [AW-1:0] limit_d, limit_q;
  logic [AW-1:0] hi_d, hi_q;
  logic [AW-1:0] lo_d, lo_q;

  // Compute region-relative addresses when a new header is loaded, else hold
  always_comb begin
    base_s = AW'(region_id) << RS_LOG2;
    if (load) begin
      start_d = base_s + AW'(offset);
      limit_d = base_s + AW'(REGION_SIZE - LEN_OFS);
      hi_d    = base_s + AW'(REGION_SIZE - LEN_OFS);
      lo_d    = base_s + AW'(REGION_SIZE - 1);
    end else begin
      start_d = start_q;
      limit_d = limit_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // Address registers, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      start_q <= '0;
      limit_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      start_q <= start_d;
      limit_q <= limit_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign ptr_start   = start_q;
  assign ptr_limit   = limit_q;
  assign len_hi_addr = hi_q;
  assign len_lo_addr = lo_q;

endmodule

// File: rtl/char_buf_writer_mr.sv
// Multi-region OSD character buffer writer: parses a 3-byte header from the
// UDP payload, writes the characters into the selected region and finishes
// with the count of written characters in the region's last two bytes.
module char_buf_writer_mr
  import char_osd_pkg::*;
#(
  parameter int unsigned NUM_REGIONS            = 4,
  parameter int unsigned REGION_SIZE            = 256,
  parameter int unsigned CHAR_BUFFER_ADDR_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [7:0]                        udp_rx_s_data_tdata,
  input  logic                              udp_rx_s_data_tlast,
  input  logic                              udp_rx_s_data_tvalid,
  output logic                              udp_rx_s_data_tready,
  input  logic [15:0]                       udp_rx_s_data_tsize,
  output logic [CHAR_BUFFER_ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]                        ram_din,
  output logic                              ram_wen,
  output logic                              busy,
  output logic                              pkt_done,
  output logic                              pkt_err,
  output logic [15:0]                       drop_cnt
);

  localparam int unsigned AW = CHAR_BUFFER_ADDR_WIDTH;

  state_t        state_d, state_q;
  logic [15:0]   tsize_d, tsize_q;
  logic [1:0]    hdr_idx_d, hdr_idx_q;
  logic [7:0]    region_d, region_q;
  logic [7:0]    off_hi_d, off_hi_q;
  logic [15:0]   data_idx_d, data_idx_q;
  logic          first_d, first_q;
  logic [AW-1:0] ptr_d, ptr_q;
  logic [15:0]   wr_cnt_d, wr_cnt_q;
  logic [AW-1:0] ram_addr_d, ram_addr_q;
  logic [7:0]    ram_din_d, ram_din_q;
  logic          ram_wen_d, ram_wen_q;
  logic          pkt_done_d, pkt_done_q;
  logic          pkt_err_d, pkt_err_q;
  logic [15:0]   drop_cnt_d, drop_cnt_q;

  logic          tready_s, accept_s, load_s, err_s;
  logic          id_ok_s, off_ok_s;
  logic [AW-1:0] cur_ptr_s;
  logic [AW-1:0] ptr_start_s, ptr_limit_s, len_hi_addr_s, len_lo_addr_s;

  assign tready_s = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_DRAIN);
  assign accept_s = tready_s && udp_rx_s_data_tvalid;
  assign id_ok_s  = udp_rx_s_data_tdata < 8'(NUM_REGIONS);
  assign off_ok_s = {off_hi_q, udp_rx_s_data_tdata} < 16'(REGION_SIZE - LEN_OFS);

  char_region_addr_gen #(
    .REGION_SIZE (REGION_SIZE),
    .AW          (AW)
  ) u_addr_gen (
    .clk         (clk),
    .resetn      (resetn),
    .load        (load_s),
    .region_id   (region_q),
    .offset      ({off_hi_q, udp_rx_s_data_tdata}),
    .ptr_start   (ptr_start_s),
    .ptr_limit   (ptr_limit_s),
    .len_hi_addr (len_hi_addr_s),
    .len_lo_addr (len_lo_addr_s)
  );

  // Next-state, write-port and status computation for the packet FSM
  always_comb begin
    state_d    = state_q;
    tsize_d    = tsize_q;
    hdr_idx_d  = hdr_idx_q;
    region_d   = region_q;
    off_hi_d   = off_hi_q;
    data_idx_d = data_idx_q;
    first_d    = first_q;
    ptr_d      = ptr_q;
    wr_cnt_d   = wr_cnt_q;
    ram_wen_d  = 1'b0;
    ram_addr_d = '0;
    ram_din_d  = 8'h00;
    pkt_done_d = 1'b0;
    pkt_err_d  = 1'b0;
    drop_cnt_d = drop_cnt_q;
    load_s     = 1'b0;
    err_s      = 1'b0;
    // The pointer register is only meaningful after the first data byte
    cur_ptr_s  = first_q ? ptr_start_s : ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (udp_rx_s_data_tvalid) begin
          tsize_d   = udp_rx_s_data_tsize;
          hdr_idx_d = 2'd0;
          state_d   = (udp_rx_s_data_tsize < 16'(HDR_BYTES)) ? ST_DRAIN : ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (accept_s) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'd0) begin
            region_d = udp_rx_s_data_tdata;
            if (udp_rx_s_data_tlast) begin
              err_s   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = id_ok_s ? ST_HDR : ST_DRAIN;
            end
          end else if (hdr_idx_q == 2'd1) begin
            off_hi_d = udp_rx_s_data_tdata;
            if (udp_rx_s_data_tlast) begin
              err_s   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HDR;
            end
          end else begin
            // Last header byte: prime the address generator for the data phase
            load_s     = 1'b1;
            first_d    = 1'b1;
            wr_cnt_d   = 16'd0;
            data_idx_d = 16'd0;
            if (!off_ok_s || (udp_rx_s_data_tlast && (tsize_q != 16'(HDR_BYTES)))) begin
              err_s   = udp_rx_s_data_tlast;
              state_d = udp_rx_s_data_tlast ? ST_IDLE : ST_DRAIN;
            end else begin
              state_d = (tsize_q == 16'(HDR_BYTES)) ? ST_LEN_HI : ST_DATA;
            end
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          first_d    = 1'b0;
          data_idx_d = data_idx_q + 16'd1;
          // Bytes past the length word are consumed but silently truncated
          if (cur_ptr_s < ptr_limit_s) begin
            ram_wen_d  = 1'b1;
            ram_addr_d = cur_ptr_s;
            ram_din_d  = udp_rx_s_data_tdata;
            ptr_d      = cur_ptr_s + AW'(1);
            wr_cnt_d   = wr_cnt_q + 16'd1;
          end else begin
            ptr_d = cur_ptr_s;
          end
          if (udp_rx_s_data_tlast || (data_idx_d == (tsize_q - 16'(HDR_BYTES)))) begin
            state_d = ST_LEN_HI;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_LEN_HI: begin
        ram_wen_d  = 1'b1;
        ram_addr_d = len_hi_addr_s;
        ram_din_d  = wr_cnt_q[15:8];
        state_d    = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        ram_wen_d  = 1'b1;
        ram_addr_d = len_lo_addr_s;
        ram_din_d  = wr_cnt_q[7:0];
        pkt_done_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_DRAIN: begin
        if (accept_s && udp_rx_s_data_tlast) begin
          err_s   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (err_s) begin
      pkt_err_d  = 1'b1;
      drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
    end else begin
      pkt_err_d  = 1'b0;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State and registered outputs; reset aborts any packet in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      tsize_q    <= 16'd0;
      hdr_idx_q  <= 2'd0;
      region_q   <= 8'd0;
      off_hi_q   <= 8'd0;
      data_idx_q <= 16'd0;
      first_q    <= 1'b0;
      ptr_q      <= '0;
      wr_cnt_q   <= 16'd0;
      ram_addr_q <= '0;
      ram_din_q  <= 8'd0;
      ram_wen_q  <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      tsize_q    <= tsize_d;
      hdr_idx_q  <= hdr_idx_d;
      region_q   <= region_d;
      off_hi_q   <= off_hi_d;
      data_idx_q <= data_idx_d;
      first_q    <= first_d;
      ptr_q      <= ptr_d;
      wr_cnt_q   <= wr_cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_wen_q  <= ram_wen_d;
      pkt_done_q <= pkt_done_d;
      pkt_err_q  <= pkt_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign udp_rx_s_data_tready = tready_s;
  assign busy                 = (state_q != ST_IDLE);
  assign ram_addr             = ram_addr_q;
  assign ram_din              = ram_din_q;
  assign ram_wen              = ram_wen_q;
  assign pkt_done             = pkt_done_q;
  assign pkt_err              = pkt_err_q;
  assign drop_cnt             = drop_cnt_q;

endmodule

// File: tb/tb_char_buf_writer_mr.sv
// Scoreboard bench for char_buf_writer_mr: a packet-level reference model
// predicts every RAM write and packet outcome; a monitor checks the DUT.
module tb_char_buf_writer_mr;

  localparam int NR = 4;
  localparam int RS = 256;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic [15:0] tsize;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_wen;
  logic        busy;
  logic        pkt_done;
  logic        pkt_err;
  logic [15:0] drop_cnt;

  char_buf_writer_mr #(
    .NUM_REGIONS            (NR),
    .REGION_SIZE            (RS),
    .CHAR_BUFFER_ADDR_WIDTH (12)
  ) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .udp_rx_s_data_tdata  (tdata),
    .udp_rx_s_data_tlast  (tlast),
    .udp_rx_s_data_tvalid (tvalid),
    .udp_rx_s_data_tready (tready),
    .udp_rx_s_data_tsize  (tsize),
    .ram_addr             (ram_addr),
    .ram_din              (ram_din),
    .ram_wen              (ram_wen),
    .busy                 (busy),
    .pkt_done             (pkt_done),
    .pkt_err              (pkt_err),
    .drop_cnt             (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t  exp_q[$];
  logic [7:0] payload[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0, err_seen = 0;
  int exp_done = 0, exp_err = 0, exp_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the head of the expectation queue
  always @(negedge clk) begin
    if (resetn) begin
      if (ram_wen) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", ram_addr, ram_din);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(e.a));
          chk("wr_data", 32'(ram_din), 32'(e.d));
        end
      end else begin
        chk("idle_port_zero", {12'd0, ram_addr, ram_din}, 32'd0);
      end
      if (pkt_done) done_seen++;
      if (pkt_err) err_seen++;
    end
  end

  task automatic put_byte(input logic [7:0] d, input logic last, input int gap_pct);
    int waited;
    if (int'($urandom_range(99)) < gap_pct) begin
      tvalid = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    waited = 0;
    while (!tready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!tready) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_idle_and_check();
    int w;
    w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
    chk("pkt_done_count", 32'(done_seen), 32'(exp_done));
    chk("pkt_err_count", 32'(err_seen), 32'(exp_err));
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    chk("tready_idle", 32'(tready), 32'd0);
    chk("writes_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_random(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
  endtask

  // Reference model: outcome of a whole packet from the header rules
  task automatic model_pkt(input int id, input int off, input int ts, input int nsent);
    bit ok;
    int nd, cnt, base;
    ok = (ts >= 3) && (nsent >= 3) && (id < NR) && (off < RS - 2) && (nsent > 3 || ts == 3);
    if (!ok) begin
      exp_err++;
      exp_drop++;
    end else begin
      nd = nsent - 3;
      base = id * RS;
      cnt = 0;
      for (int k = 0; k < nd; k++) begin
        if (off + k < RS - 2) begin
          exp_q.push_back({12'(base + off + k), payload[k]});
          cnt++;
        end
      end
      exp_q.push_back({12'(base + RS - 2), 8'(cnt >> 8)});
      exp_q.push_back({12'(base + RS - 1), 8'(cnt & 255)});
      exp_done++;
    end
  endtask

  task automatic drive_pkt(input int id, input int off, input int ts, input int nsent, input int gap_pct);
    logic [7:0] b;
    tsize = 16'(ts);
    for (int i = 0; i < nsent; i++) begin
      if (i == 0) b = 8'(id);
      else if (i == 1) b = 8'(off >> 8);
      else if (i == 2) b = 8'(off & 255);
      else b = payload[i-3];
      put_byte(b, (i == nsent - 1), gap_pct);
    end
  endtask

  task automatic send_pkt(input int id, input int off, input int ts, input int nsent, input int gap_pct);
    if (payload.size() < nsent) fill_random(nsent);
    model_pkt(id, off, ts, nsent);
    drive_pkt(id, off, ts, nsent, gap_pct);
    wait_idle_and_check();
  endtask

  initial begin
    int id, off, ts, ns;
    resetn = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = 8'd0;
    tsize  = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_wen", 32'(ram_wen), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_flags", {30'd0, pkt_done, pkt_err}, 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // "HELLO" to region 1
    payload = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    send_pkt(1, 0, 8, 8, 0);
    // Truncation at the end of region 0
    fill_random(10);
    send_pkt(0, 250, 13, 13, 0);
    // Invalid region id
    fill_random(6);
    send_pkt(7, 0, 6, 6, 0);
    // 50% gaps, region 2 offset 16, 32 chars
    fill_random(32);
    send_pkt(2, 16, 35, 35, 50);
    // Early tlast on the 2nd data byte, then a clean packet
    fill_random(17);
    send_pkt(3, 10, 20, 5, 0);
    fill_random(4);
    send_pkt(3, 100, 7, 7, 0);
    // Header-only packet and an offset right on the boundary
    fill_random(1);
    send_pkt(2, 0, 3, 3, 0);
    send_pkt(1, 254, 6, 6, 0);

    // Reset in the middle of the data phase of region 3
    fill_random(15);
    tsize = 16'd20;
    for (int k = 0; k < 5; k++) exp_q.push_back({12'(3 * RS + k), payload[k]});
    put_byte(8'd3, 1'b0, 0);
    put_byte(8'd0, 1'b0, 0);
    put_byte(8'd0, 1'b0, 0);
    for (int k = 0; k < 5; k++) put_byte(payload[k], 1'b0, 0);
    @(negedge clk);
    chk("pre_rst_pending", 32'(exp_q.size()), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_wen", 32'(ram_wen), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_flags", {30'd0, pkt_done, pkt_err}, 32'd0);
    chk("midrst_drop", 32'(drop_cnt), 32'd0);
    exp_drop = 0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    fill_random(8);
    send_pkt(3, 0, 11, 11, 0);

    // Randomised packets, including drops, early tlast and truncation
    for (int p = 0; p < 25; p++) begin
      id  = ($urandom_range(9) == 0) ? int'($urandom_range(15, 4)) : int'($urandom_range(3, 0));
      off = ($urandom_range(3) == 0) ? int'($urandom_range(300, 240)) : int'($urandom_range(200, 0));
      ts  = ($urandom_range(9) == 0) ? int'($urandom_range(2, 0)) : int'($urandom_range(24, 3));
      if (ts < 3) ns = (ts < 1) ? 1 : ts;
      else ns = ($urandom_range(4) == 0) ? int'($urandom_range(ts, 1)) : ts;
      fill_random(ns);
      send_pkt(id, off, ts, ns, 50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
